branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Parametrised fetch-stage branch predictor, the successor to the execute-stage target adder; replaces "predict not-taken, redirect from execute".
- Direct-mapped BTB with a per-entry saturating direction counter.
- Fetch looks up the current PC combinationally.
- Execute reports each resolved control-flow op; the block flags misprediction, drives the redirect PC and trains its tables on the next edge.

Parameters:
- ENTRIES, 64, number of BTB entries; power of 2, at least 2.
- CNT_W, 2, width of the direction counter; at least 1.
- TAG_W, 16, stored tag bits.
- ADDR_W, 64, address width; matches addr_t.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- f_pc  in  ADDR_W  fetch PC being looked up
- f_pred_taken  out  1  prediction: redirect fetch
- f_pred_target  out  ADDR_W  predicted next PC
- u_valid  in  1  a resolved control-flow op is presented this cycle
- u_kind  in  2  br_kind_t: BK_NONE, BK_COND, BK_JAL, BK_JALR
- u_pc  in  ADDR_W  PC of the resolved op
- u_taken  in  1  actual direction; JAL/JALR always 1
- u_target  in  ADDR_W  actual target: pc+imm, or (rs1+imm) with bit 0 cleared for JALR
- u_pred_taken  in  1  prediction this op was fetched with, carried down the pipe
- u_pred_target  in  ADDR_W  predicted target carried down the pipe
- mispredict  out  1  execute must flush younger ops and redirect
- redirect_pc  out  ADDR_W  correct next PC when mispredict=1
- mispredict_cnt  out  32  saturating count of mispredictions

Behaviour:
- Index and tag:
  - IDX_W = log2(ENTRIES).
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
- Lookup (combinational, zero latency):
  - hit = valid[idx] && tag[idx]==tag(f_pc).
  - f_pred_taken = hit && (kind is JAL/JALR || cnt MSB==1).
  - f_pred_target = target[idx] if f_pred_taken, else f_pc+4.
- Resolve (combinational, gated by u_valid; u_kind==BK_NONE resolves as a not-taken op):
  - actual = u_taken ? u_target : u_pc+4.
  - mispredict = u_valid && (u_pred_taken != u_taken || (u_taken && u_pred_target != u_target)).
  - redirect_pc = actual when mispredict=1, else 0.
- Update (registered, on the clk edge when u_valid && u_kind != BK_NONE); "hit" here means the u_pc entry hits:
  - BK_COND, hit: counter saturating increment if taken, decrement if not. Target written when taken.
  - BK_COND, miss, taken: allocate entry (valid, tag, kind, target), counter = weakly taken (1 followed by zeros).
  - BK_COND, miss, not taken: no write.
  - BK_JAL / BK_JALR, hit or miss: allocate or overwrite entry (valid, tag, kind, target), counter = all ones.
  - An allocation on a miss evicts the previous occupant unconditionally.
- Counter:
  - Saturates at all-ones and at zero; never wraps.
- Simultaneous lookup and update to the same idx:
  - Lookup returns pre-update contents (read-before-write); the new state is visible the following cycle.
- mispredict_cnt:
  - Increments on each cycle with mispredict=1.
  - Holds at 32'hFFFF_FFFF.
- Reset (synchronous, active-high):
  - All valid bits cleared; counters set to weakly not-taken (0 followed by ones); mispredict_cnt=0.
  - Targets and tags need not be reset.
  - With reset asserted: outputs follow the combinational rules on reset contents, so f_pred_taken=0; no table writes occur even if u_valid=1.
  - mispredict is still computed from the inputs; the pipeline discards it during reset.
- f_pc and u_pc are word-aligned; bits [1:0] are ignored.

Decomposition:
- Package bpu_pkg, under include/ beside common/pipes:
  - br_kind_t enum.
  - btb_entry_t struct {valid, tag, kind, target}.
  - Function for the weakly-taken / weakly-not-taken reset constants.
- Sub-module sat_cnt:
  - Combinational next-value of a CNT_W saturating counter from (cnt, inc).
  - Instantiated once on the update path.
- Table storage lives in branch_predictor, as register arrays, not SRAM.

Test Plan:
- Reset, then f_pc=0x8000_0000 -> f_pred_taken=0, f_pred_target=0x8000_0004, mispredict_cnt=0.
- Update BK_JAL, u_pc=0x8000_0010, u_target=0x8000_0100, u_pred_taken=0 -> mispredict=1, redirect_pc=0x8000_0100; next cycle f_pc=0x8000_0010 -> f_pred_taken=1, f_pred_target=0x8000_0100; mispredict_cnt=1.
- BK_COND at 0x8000_0020, taken to 0x8000_0040, three times -> counter 10, 11, 11 (saturated); then one not-taken -> counter 10, lookup still predicts taken; a second not-taken -> counter 01, lookup predicts not-taken with target 0x8000_0024.
- Aliasing: JAL at 0x8000_0010, then BK_COND taken at 0x8000_0010 + ENTRIES*4 (same idx, different tag) -> old entry evicted; lookup of 0x8000_0010 returns not-taken, pc+4.
- Same-cycle lookup and update on the same idx -> prediction reflects old state; next cycle reflects new state.
- Correct prediction (u_pred_taken=1, u_pred_target=u_target=0x8000_0200, u_taken=1) -> mispredict=0, redirect_pc=0, counter unchanged.
- Reset asserted with u_valid=1 -> no table write.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and constants for the fetch-stage branch predictor:
// control-flow kinds, the BTB entry layout and counter reset constants.
package bpu_pkg;

  localparam int unsigned BPU_ADDR_W = 64;
  localparam int unsigned BPU_TAG_W  = 16;

  typedef logic [BPU_ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    BK_NONE = 2'd0,
    BK_COND = 2'd1,
    BK_JAL  = 2'd2,
    BK_JALR = 2'd3
  } br_kind_t;

  typedef struct packed {
    logic                 valid;
    logic [BPU_TAG_W-1:0] tag;
    br_kind_t             kind;
    addr_t                target;
  } btb_entry_t;

  // Weakly taken is 10..0, weakly not-taken is 01..1 for a w-bit counter.
  function automatic logic [31:0] cnt_weak(int unsigned w, logic taken);
    logic [31:0] half;
    half = 32'd1 << (w - 1);
    return taken ? half : (half - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup and execute resolve signals shared by the predictor and the
// pipeline; the pipeline is the master, the predictor the slave.
interface branch_predictor_if
  import bpu_pkg::*;
#(
  parameter int unsigned ADDR_W = BPU_ADDR_W
);

  logic [ADDR_W-1:0] f_pc;
  logic              f_pred_taken;
  logic [ADDR_W-1:0] f_pred_target;

  logic              u_valid;
  br_kind_t          u_kind;
  logic [ADDR_W-1:0] u_pc;
  logic              u_taken;
  logic [ADDR_W-1:0] u_target;
  logic              u_pred_taken;
  logic [ADDR_W-1:0] u_pred_target;

  logic              mispredict;
  logic [ADDR_W-1:0] redirect_pc;
  logic [31:0]       mispredict_cnt;

  modport master (
    output f_pc, u_valid, u_kind, u_pc, u_taken, u_target, u_pred_taken, u_pred_target,
    input  f_pred_taken, f_pred_target, mispredict, redirect_pc, mispredict_cnt
  );

  modport slave (
    input  f_pc, u_valid, u_kind, u_pc, u_taken, u_target, u_pred_taken, u_pred_target,
    output f_pred_taken, f_pred_target, mispredict, redirect_pc, mispredict_cnt
  );

endinterface

// File: rtl/branch_predictor_sat_cnt.sv
// Next value of a W-bit saturating up/down direction counter.
module sat_cnt #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] cnt_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  always_comb begin
    cnt_o = cnt_i;
    if (inc_i) begin
      if (cnt_i != '1) cnt_o = cnt_i + W'(1);
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters; zero-latency
// fetch lookup, execute-stage mispredict detection and next-edge training.
module branch_predictor
  import bpu_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned CNT_W   = 2,
  parameter int unsigned TAG_W   = 16,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_if.slave  bp
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(cnt_weak(CNT_W, 1'b1));
  localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_W'(cnt_weak(CNT_W, 1'b0));

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    br_kind_t          kind;
    logic [ADDR_W-1:0] target;
  } entry_t;

  entry_t            btb_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q [ENTRIES];
  logic [31:0]       mcnt_q, mcnt_d;

  logic [IDX_W-1:0]  f_idx, u_idx;
  logic [TAG_W-1:0]  f_tag, u_tag;
  entry_t            f_e, u_e;
  logic              f_hit, u_hit;

  logic              u_eff_taken;
  logic [ADDR_W-1:0] u_actual;
  logic              mispredict;

  logic              upd_en, alloc, tgt_wr, cnt_wr;
  logic [CNT_W-1:0]  cnt_d, cnt_nxt;

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.f_pc[1:0], bp.u_pc[1:0],
                            bp.f_pc[ADDR_W-1:IDX_W+TAG_W+2], bp.u_pc[ADDR_W-1:IDX_W+TAG_W+2]};

  assign f_idx = bp.f_pc[IDX_W+1:2];
  assign f_tag = bp.f_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_idx = bp.u_pc[IDX_W+1:2];
  assign u_tag = bp.u_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign f_e   = btb_q[f_idx];
  assign u_e   = btb_q[u_idx];
  assign f_hit = f_e.valid && (f_e.tag == f_tag);
  assign u_hit = u_e.valid && (u_e.tag == u_tag);

  // Lookup reads the registered table, so a same-cycle update is seen next cycle.
  always_comb begin
    bp.f_pred_taken  = f_hit && (f_e.kind == BK_JAL || f_e.kind == BK_JALR || cnt_q[f_idx][CNT_W-1]);
    bp.f_pred_target = bp.f_pred_taken ? f_e.target : bp.f_pc + ADDR_W'(4);
  end

  always_comb begin
    u_eff_taken = bp.u_taken && (bp.u_kind != BK_NONE);
    u_actual    = u_eff_taken ? bp.u_target : bp.u_pc + ADDR_W'(4);
    mispredict  = bp.u_valid && ((bp.u_pred_taken != u_eff_taken) ||
                                 (u_eff_taken && (bp.u_pred_target != bp.u_target)));
    bp.mispredict     = mispredict;
    bp.redirect_pc    = mispredict ? u_actual : '0;
    bp.mispredict_cnt = mcnt_q;
  end

  sat_cnt #(.W(CNT_W)) u_sat_cnt (
    .cnt_i (cnt_q[u_idx]),
    .inc_i (bp.u_taken),
    .cnt_o (cnt_nxt)
  );

  assign upd_en = bp.u_valid && (bp.u_kind != BK_NONE) && !reset;

  always_comb begin
    alloc  = 1'b0;
    tgt_wr = 1'b0;
    cnt_wr = 1'b0;
    cnt_d  = cnt_q[u_idx];
    if (upd_en) begin
      case (bp.u_kind)
        BK_COND: begin
          if (u_hit) begin
            cnt_wr = 1'b1;
            cnt_d  = cnt_nxt;
            tgt_wr = bp.u_taken;
          end else if (bp.u_taken) begin
            alloc  = 1'b1;
            cnt_wr = 1'b1;
            cnt_d  = CNT_WEAK_T;
          end
        end
        BK_JAL, BK_JALR: begin
          alloc  = 1'b1;
          cnt_wr = 1'b1;
          cnt_d  = '1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    mcnt_d = mcnt_q;
    if (mispredict && mcnt_q != '1) mcnt_d = mcnt_q + 32'd1;
  end

  // Tags and targets are left untouched by reset; only valid and counters clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i].valid <= 1'b0;
        cnt_q[i]       <= CNT_WEAK_NT;
      end
      mcnt_q <= '0;
    end else begin
      if (alloc) begin
        btb_q[u_idx] <= '{valid: 1'b1, tag: u_tag, kind: bp.u_kind, target: bp.u_target};
      end else if (tgt_wr) begin
        btb_q[u_idx].target <= bp.u_target;
      end
      if (cnt_wr) cnt_q[u_idx] <= cnt_d;
      mcnt_q <= mcnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed and randomized checks of branch_predictor against a table model.
module tb_branch_predictor;
  import bpu_pkg::*;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned TAG_W   = 16;
  localparam int unsigned ADDR_W  = 64;
  localparam int unsigned IDX_W   = 4;
  localparam int          CMAX    = 3;
  localparam int          HALF    = 2;
  localparam longint unsigned BASE = 64'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_W(ADDR_W)) bp ();

  branch_predictor #(.ENTRIES(ENTRIES), .CNT_W(CNT_W), .TAG_W(TAG_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bp.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  bit              m_valid [ENTRIES];
  longint unsigned m_tag   [ENTRIES];
  int              m_kind  [ENTRIES];
  longint unsigned m_tgt   [ENTRIES];
  int              m_cnt   [ENTRIES];
  longint unsigned m_mcnt;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic int idx_of(input longint unsigned pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic longint unsigned tag_of(input longint unsigned pc);
    return (pc >> (IDX_W + 2)) & ((64'd1 << TAG_W) - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0;
      m_cnt[i]   = HALF - 1;
    end
    m_mcnt = 0;
  endtask

  task automatic model_lookup(input longint unsigned pc, output bit tk, output longint unsigned tgt);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    tk  = hit && (m_kind[i] == int'(BK_JAL) || m_kind[i] == int'(BK_JALR) || m_cnt[i] >= HALF);
    tgt = tk ? m_tgt[i] : pc + 4;
  endtask

  task automatic model_alloc(input int i, input br_kind_t k, input longint unsigned pc,
                             input longint unsigned tgt, input int cnt);
    m_valid[i] = 1;
    m_tag[i]   = tag_of(pc);
    m_kind[i]  = int'(k);
    m_tgt[i]   = tgt;
    m_cnt[i]   = cnt;
  endtask

  task automatic model_update(input br_kind_t k, input longint unsigned pc, input bit tk,
                              input longint unsigned tgt);
    int i;
    bit hit;
    i   = idx_of(pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(pc));
    if (k == BK_COND) begin
      if (hit) begin
        if (tk) begin
          m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
          m_tgt[i] = tgt;
        end else begin
          m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        end
      end else if (tk) begin
        model_alloc(i, k, pc, tgt, HALF);
      end
    end else if (k == BK_JAL || k == BK_JALR) begin
      model_alloc(i, k, pc, tgt, CMAX);
    end
  endtask

  // One cycle: drive, check combinational outputs, clock, check the counter.
  task automatic step(input logic rst, input logic v, input br_kind_t k,
                      input longint unsigned upc, input logic tk, input longint unsigned tgt,
                      input logic pt, input longint unsigned ptgt, input longint unsigned fpc);
    bit              etk, eff, mp;
    longint unsigned etgt, rdr;
    reset            = rst;
    bp.u_valid       = v;
    bp.u_kind        = k;
    bp.u_pc          = upc;
    bp.u_taken       = tk;
    bp.u_target      = tgt;
    bp.u_pred_taken  = pt;
    bp.u_pred_target = ptgt;
    bp.f_pc          = fpc;
    #2;
    model_lookup(fpc, etk, etgt);
    check("f_pred_taken", 64'(bp.f_pred_taken), 64'(etk));
    check("f_pred_target", bp.f_pred_target, etgt);
    eff = tk && (k != BK_NONE);
    mp  = v && ((pt != eff) || (eff && ptgt != tgt));
    rdr = mp ? (eff ? tgt : upc + 4) : 0;
    check("mispredict", 64'(bp.mispredict), 64'(mp));
    check("redirect_pc", bp.redirect_pc, rdr);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (v && k != BK_NONE) model_update(k, upc, tk, tgt);
      if (mp && m_mcnt != 64'hFFFF_FFFF) m_mcnt++;
    end
    #1;
    check("mispredict_cnt", 64'(bp.mispredict_cnt), m_mcnt);
  endtask

  task automatic idle(input longint unsigned fpc);
    step(1'b0, 1'b0, BK_NONE, 0, 1'b0, 0, 1'b0, 0, fpc);
  endtask

  initial begin
    bit              rpt;
    longint unsigned rptgt, rupc, rtgt;
    br_kind_t        rk;
    logic            rtk;

    reset            = 1'b1;
    bp.u_valid       = 1'b0;
    bp.u_kind        = BK_NONE;
    bp.u_pc          = '0;
    bp.u_taken       = 1'b0;
    bp.u_target      = '0;
    bp.u_pred_taken  = 1'b0;
    bp.u_pred_target = '0;
    bp.f_pc          = BASE;
    repeat (2) @(posedge clk);
    model_reset();
    #1;

    idle(BASE);
    check("reset_cnt", 64'(bp.mispredict_cnt), 64'd0);

    step(1'b0, 1'b1, BK_JAL, BASE + 'h10, 1'b1, BASE + 'h100, 1'b0, 0, BASE);
    check("jal_cnt", 64'(bp.mispredict_cnt), 64'd1);
    idle(BASE + 'h10);

    for (int n = 0; n < 3; n++)
      step(1'b0, 1'b1, BK_COND, BASE + 'h20, 1'b1, BASE + 'h40, 1'b0, 0, BASE + 'h20);
    for (int n = 0; n < 2; n++)
      step(1'b0, 1'b1, BK_COND, BASE + 'h20, 1'b0, 0, 1'b1, BASE + 'h40, BASE + 'h20);
    idle(BASE + 'h20);

    step(1'b0, 1'b1, BK_COND, BASE + 'h10 + ENTRIES * 4, 1'b1, BASE + 'h300, 1'b0, 0, BASE + 'h10);
    idle(BASE + 'h10);

    step(1'b0, 1'b1, BK_COND, BASE + 'h80, 1'b1, BASE + 'h180, 1'b0, 0, BASE + 'h80);
    idle(BASE + 'h80);

    step(1'b0, 1'b1, BK_JAL, BASE + 'h30, 1'b1, BASE + 'h200, 1'b1, BASE + 'h200, BASE + 'h30);
    idle(BASE + 'h30);

    step(1'b1, 1'b1, BK_JAL, BASE + 'h50, 1'b1, BASE + 'h500, 1'b0, 0, BASE + 'h50);
    idle(BASE + 'h50);

    for (int n = 0; n < 600; n++) begin
      rupc = BASE + longint'($urandom_range(0, 47)) * 4;
      rk   = br_kind_t'($urandom_range(0, 3));
      rtk  = (rk == BK_JAL || rk == BK_JALR) ? 1'b1 : 1'($urandom_range(0, 1));
      rtgt = BASE + longint'($urandom_range(0, 255)) * 4;
      if ($urandom_range(0, 1) == 1) begin
        model_lookup(rupc, rpt, rptgt);
      end else begin
        rpt   = 1'($urandom_range(0, 1));
        rptgt = ($urandom_range(0, 1) == 1) ? rtgt : BASE + longint'($urandom_range(0, 255)) * 4;
      end
      step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 7) != 0), rk, rupc, rtk, rtgt,
           rpt, rptgt, BASE + longint'($urandom_range(0, 47)) * 4);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
